keypad_event_scanner: RTL and testbench
=======================================

// Module: keypad_event_scanner
// PURPOSE
//   Scans the 3x4 telephone keypad, debounces it and emits one event per physical key press.
//   Events go into a small FIFO with a valid/ready handshake.
//   Sits directly upstream of the tic-tac-toe game core, replacing its raw level-type key_data.
//   A held key produces exactly one move.
// PARAMETERS
//   SCAN_DIV        12499  scan tick every SCAN_DIV+1 clk cycles (~2 kHz at 25 MHz)
//   DEBOUNCE_TICKS  4      consecutive identical samples to accept a press or a release (1..15)
//   FIFO_DEPTH      4      event FIFO entries, power of two, >=2
// PORTS
//   clk          in   1  system clock, 25 MHz
//   rst          in   1  synchronous, active-high reset
//   key_row      in   4  keypad rows; bit0 = top row (1,2,3), bit3 = bottom row (*,0,#); 1 = pressed
//   key_col      out  3  one-hot column drive: 001 = col 1,4,7,*; 010 = col 2,5,8,0; 100 = col 3,6,9,#
//   evt_valid    out  1  FIFO head holds an event
//   evt_ready    in   1  consumer accepts head this cycle
//   evt_code     out  4  0-9 digits, 10 = '*', 11 = '#'; 12-15 never produced
//   evt_release  out  1  head is a release event (tied 0 without KEYPAD_RELEASE_EN)
//   key_held     out  1  debounced key currently down (PRESSED state)
//   overflow     out  1  sticky: an event was dropped because the FIFO was full
// BEHAVIOUR
//   Reset values
//     - key_col = 000; state = SCAN; FIFO empty.
//     - evt_valid = evt_release = key_held = overflow = 0; evt_code = 0.
//   Tick generator
//     - Counter 0..SCAN_DIV; tick = 1 clk pulse at SCAN_DIV; wraps to 0.
//     - All FSM sampling happens only on tick cycles.
//   Row qualification
//     - Valid sample = exactly one key_row bit set.
//     - 0 bits or >=2 bits = "no key" (ghost rejection).
//   State machine
//     - SCAN, tick: first tick after reset 000 -> 001. Then if row valid, capture col/row, dbcnt = 1,
//       go to DEBOUNCE with the column frozen; else rotate 001 -> 010 -> 100 -> 001.
//     - DEBOUNCE, tick: same row as captured -> dbcnt++; when dbcnt == DEBOUNCE_TICKS, push press
//       event, go to PRESSED. Any other sample -> rotate column, back to SCAN, no event.
//     - PRESSED (key_held = 1, column frozen), tick: sample "no key" -> relcnt++, else relcnt = 0.
//       When relcnt == DEBOUNCE_TICKS, push release event (macro only), go to SCAN, rotate column.
//       A second key pressed while held is ignored.
//   Latency: push on the qualifying tick cycle; evt_valid rises the following clk if the FIFO was empty.
//   FIFO (show-ahead)
//     - evt_code/evt_release reflect the head while evt_valid = 1.
//     - Pop when evt_valid & evt_ready. evt_ready while empty has no effect.
//     - Push while full and no pop: drop the new event, set overflow; held until rst.
//     - Push and pop in the same cycle while full: both occur, no overflow, count unchanged.
//   Reset mid-debounce or mid-press: everything returns to reset values next clk; no event is emitted.
//   Arithmetic: evt_code = {row index, column index} map via a constant table; counters saturate, never wrap.
// CONFIGURATION
//   KEYPAD_RELEASE_EN
//     - Defined: release events are pushed with evt_release = 1 and the code of the released key.
//     - Undefined: no release events; evt_release tied 0; release debounce still runs.
// STRUCTURE
//   keypad_pkg
//     - Column one-hot constants COL1/COL2/COL3.
//     - KEY_STAR = 10, KEY_HASH = 11.
//     - State enum SCAN/DEBOUNCE/PRESSED.
//     - Function row_col_to_code.
//   Sub-module key_event_fifo: parameterised sync FIFO, width 5 ({release, code}), with an overflow flag.
// TESTING (bench uses SCAN_DIV = 3, DEBOUNCE_TICKS = 4, FIFO_DEPTH = 4)
//   1. rst, then no keys for 12 ticks -> key_col cycles 001, 010, 100, 001 ...; evt_valid stays 0.
//   2. key_row = 0010 held while key_col = 010, for 10 ticks, evt_ready = 1 -> exactly one event,
//      code 5, on the 4th matching tick; key_held = 1.
//   3. Bounce: row 0001 at col 001 for 2 ticks, 0 for 1 tick, then stable -> press accepted only
//      after 4 stable ticks; one event, code 1.
//   4. evt_ready = 0, five presses of 1,2,3,4,5 (macro off) -> 4 queued (1,2,3,4); overflow = 1;
//      draining yields 1,2,3,4.
//   5. key_row = 1001 (two rows) -> no event; press # (row 1000, col 100) -> code 11.
//      With KEYPAD_RELEASE_EN: releasing # -> second event, code 11, evt_release = 1.
//   6. rst asserted during DEBOUNCE of key 9 -> next clk: key_col = 000, evt_valid = 0; no event
//      emitted after rst drops while the key is still held until a full debounce completes.

Source files
------------

// File: rtl/keypad_pkg.sv
// Shared constants, scan-state type and key-code helpers for the 3x4 keypad event scanner.
package keypad_pkg;

  localparam logic [2:0] COL1 = 3'b001;
  localparam logic [2:0] COL2 = 3'b010;
  localparam logic [2:0] COL3 = 3'b100;

  localparam logic [3:0] KEY_STAR = 4'd10;
  localparam logic [3:0] KEY_HASH = 4'd11;

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    PRESSED  = 2'd2
  } scan_state_t;

  // Exactly one row asserted; zero or several rows count as "no key" (ghost rejection).
  function automatic logic row_is_single(input logic [3:0] row);
    return (row != 4'b0000) && ((row & (row - 4'd1)) == 4'b0000);
  endfunction

  function automatic logic [2:0] next_col(input logic [2:0] col);
    case (col)
      COL1:    return COL2;
      COL2:    return COL3;
      default: return COL1;
    endcase
  endfunction

  function automatic logic [3:0] sat_inc(input logic [3:0] value);
    return (value == 4'hF) ? value : value + 4'd1;
  endfunction

  function automatic logic [3:0] row_col_to_code(input logic [3:0] row, input logic [2:0] col);
    logic [1:0] r;
    logic [1:0] c;
    logic [3:0] code;
    case (row)
      4'b0001: r = 2'd0;
      4'b0010: r = 2'd1;
      4'b0100: r = 2'd2;
      default: r = 2'd3;
    endcase
    case (col)
      COL1:    c = 2'd0;
      COL2:    c = 2'd1;
      default: c = 2'd2;
    endcase
    case ({r, c})
      4'h0:    code = 4'd1;
      4'h1:    code = 4'd2;
      4'h2:    code = 4'd3;
      4'h4:    code = 4'd4;
      4'h5:    code = 4'd5;
      4'h6:    code = 4'd6;
      4'h8:    code = 4'd7;
      4'h9:    code = 4'd8;
      4'hA:    code = 4'd9;
      4'hC:    code = KEY_STAR;
      4'hD:    code = 4'd0;
      4'hE:    code = KEY_HASH;
      default: code = 4'd0;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/key_event_fifo.sv
// Show-ahead synchronous FIFO for key events with a sticky overflow flag.
module key_event_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop_ready,
  output logic             valid,
  output logic [WIDTH-1:0] head,
  output logic             overflow
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             full;
  logic             pop;
  logic             wr_en;

  assign valid = (count != '0);
  assign full  = (count == (AW+1)'(DEPTH));
  assign pop   = valid & pop_ready;
  assign wr_en = push & (~full | pop);
  // Head reads as zero while empty so the outputs carry defined values out of reset.
  assign head  = valid ? mem[rd_ptr] : '0;

  // NOTE: storage has no reset; occupancy is tracked by count, so stale entries are never exposed.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (pop)   rd_ptr <= rd_ptr + AW'(1);
      case ({wr_en, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
      if (push && full && !pop) overflow <= 1'b1;
    end
  end

endmodule

// File: rtl/keypad_event_scanner.sv
// 3x4 keypad scanner/debouncer emitting one FIFO event per key press.
// Define KEYPAD_RELEASE_EN to also emit release events (evt_release = 1).
module keypad_event_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV       = 12499,
  parameter int DEBOUNCE_TICKS = 4,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] key_row,
  output logic [2:0] key_col,
  output logic       evt_valid,
  input  logic       evt_ready,
  output logic [3:0] evt_code,
  output logic       evt_release,
  output logic       key_held,
  output logic       overflow
);

  localparam int              DIV_W    = (SCAN_DIV > 0) ? $clog2(SCAN_DIV + 1) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV);
  localparam logic [3:0]      DB_LAST  = 4'(DEBOUNCE_TICKS);

  logic [DIV_W-1:0] div_cnt;
  logic             tick;
  scan_state_t      state, state_nxt;
  logic [2:0]       col_nxt;
  logic [3:0]       cap_row, cap_row_nxt;
  logic [3:0]       dbcnt, dbcnt_nxt;
  logic [3:0]       relcnt, relcnt_nxt;
  logic             row_ok;
  logic             push;
  logic             push_rel;
  logic [3:0]       push_code;
  logic [4:0]       head;

  assign tick     = (div_cnt == DIV_LAST);
  assign row_ok   = row_is_single(key_row);
  assign key_held = (state == PRESSED);
  // The column is frozen outside SCAN, so key_col still names the captured key's column.
  assign push_code = row_col_to_code((state == SCAN) ? key_row : cap_row, key_col);

  // NOTE: every output of this block is defaulted first, so no path can infer a latch.
  always_comb begin
    state_nxt   = state;
    col_nxt     = key_col;
    cap_row_nxt = cap_row;
    dbcnt_nxt   = dbcnt;
    relcnt_nxt  = relcnt;
    push        = 1'b0;
    push_rel    = 1'b0;
    if (tick) begin
      unique case (state)
        SCAN: begin
          if (key_col == 3'b000) begin
            col_nxt = COL1;
          end else if (row_ok) begin
            cap_row_nxt = key_row;
            dbcnt_nxt   = 4'd1;
            relcnt_nxt  = 4'd0;
            if (DB_LAST == 4'd1) begin
              push      = 1'b1;
              state_nxt = PRESSED;
            end else begin
              state_nxt = DEBOUNCE;
            end
          end else begin
            col_nxt = next_col(key_col);
          end
        end
        DEBOUNCE: begin
          if (key_row == cap_row) begin
            dbcnt_nxt = sat_inc(dbcnt);
            if (sat_inc(dbcnt) == DB_LAST) begin
              push       = 1'b1;
              relcnt_nxt = 4'd0;
              state_nxt  = PRESSED;
            end
          end else begin
            col_nxt   = next_col(key_col);
            state_nxt = SCAN;
          end
        end
        PRESSED: begin
          // Any single-row sample (including a second key) restarts the release count.
          relcnt_nxt = row_ok ? 4'd0 : sat_inc(relcnt);
          if (!row_ok && sat_inc(relcnt) == DB_LAST) begin
`ifdef KEYPAD_RELEASE_EN
            push     = 1'b1;
            push_rel = 1'b1;
`endif
            relcnt_nxt = 4'd0;
            col_nxt    = next_col(key_col);
            state_nxt  = SCAN;
          end
        end
        default: state_nxt = SCAN;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt <= '0;
      state   <= SCAN;
      key_col <= 3'b000;
      cap_row <= 4'd0;
      dbcnt   <= 4'd0;
      relcnt  <= 4'd0;
    end else begin
      div_cnt <= tick ? '0 : div_cnt + DIV_W'(1);
      state   <= state_nxt;
      key_col <= col_nxt;
      cap_row <= cap_row_nxt;
      dbcnt   <= dbcnt_nxt;
      relcnt  <= relcnt_nxt;
    end
  end

  key_event_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (5)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data ({push_rel, push_code}),
    .pop_ready (evt_ready),
    .valid     (evt_valid),
    .head      (head),
    .overflow  (overflow)
  );

  assign evt_code    = head[3:0];
  assign evt_release = head[4];

endmodule

// File: tb/tb_keypad_event_scanner.sv
// Scoreboard bench for keypad_event_scanner; physical keypad model drives key_row from key_col.
`timescale 1ns/1ps
module tb_keypad_event_scanner;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] key_row;
  logic [2:0] key_col;
  logic       evt_valid;
  logic       evt_ready = 1'b0;
  logic [3:0] evt_code;
  logic       evt_release;
  logic       key_held;
  logic       overflow;

  logic [3:0] phys_c0 = 4'd0;
  logic [3:0] phys_c1 = 4'd0;
  logic [3:0] phys_c2 = 4'd0;

  int         checks = 0;
  int         errors = 0;
  logic [4:0] exp_q[$];
  logic [4:0] mon_exp;
  bit         hold_mode = 1'b0;
  int         model_occ = 0;
  int         dropped = 0;

  logic [1:0] tb_cnt;
  logic       tb_tick;

  always #5 clk = ~clk;

  keypad_event_scanner #(
    .SCAN_DIV       (3),
    .DEBOUNCE_TICKS (4),
    .FIFO_DEPTH     (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .key_row     (key_row),
    .key_col     (key_col),
    .evt_valid   (evt_valid),
    .evt_ready   (evt_ready),
    .evt_code    (evt_code),
    .evt_release (evt_release),
    .key_held    (key_held),
    .overflow    (overflow)
  );

  // Physical keypad: a pressed key connects its row to its column drive.
  assign key_row = ({4{key_col[0]}} & phys_c0) | ({4{key_col[1]}} & phys_c1) |
                   ({4{key_col[2]}} & phys_c2);

  // Reference scan-tick timing: a tick every 4 clocks, counted from reset release.
  always @(posedge clk) begin
    if (rst) tb_cnt <= 2'd0;
    else     tb_cnt <= tb_cnt + 2'd1;
  end
  assign tb_tick = (tb_cnt == 2'd3);

  always @(negedge clk) begin
    if (!rst && evt_valid && evt_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_event: got rel=%0b code=%0d, required no event", evt_release, evt_code);
      end else begin
        mon_exp = exp_q.pop_front();
        if ({evt_release, evt_code} !== mon_exp) begin
          errors++;
          $display("FAIL event: got rel=%0b code=%0d, required rel=%0b code=%0d",
                   evt_release, evt_code, mon_exp[4], mon_exp[3:0]);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end

  task automatic set_key(input logic [3:0] rows, input logic [2:0] col);
    phys_c0 = col[0] ? rows : 4'd0;
    phys_c1 = col[1] ? rows : 4'd0;
    phys_c2 = col[2] ? rows : 4'd0;
  endtask

  task automatic clear_keys();
    phys_c0 = 4'd0;
    phys_c1 = 4'd0;
    phys_c2 = 4'd0;
  endtask

  task automatic expect_event(input logic rel, input logic [3:0] code);
    if (hold_mode) begin
      if (model_occ >= 4) dropped++;
      else begin
        exp_q.push_back({rel, code});
        model_occ++;
      end
    end else begin
      exp_q.push_back({rel, code});
    end
  endtask

  task automatic wait_ticks(input int n);
    repeat (4 * n) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wait_held(input logic level, input string name);
    int n = 0;
    while (key_held !== level && n < 400) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (key_held !== level) begin
      errors++;
      $display("FAIL %s: key_held=%b, required %b within 400 clocks", name, key_held, level);
    end
  endtask

  // Returns at the negedge after the n-th tick that sampled the given key.
  task automatic count_matches(input logic [3:0] rows, input logic [2:0] col, input int target,
                               input string name);
    int m = 0;
    int c = 0;
    while (m < target && c < 400) begin
      @(negedge clk);
      c++;
      if (tb_tick && key_col == col && key_row == rows) begin
        @(negedge clk);
        c++;
        m++;
      end
    end
    checks++;
    if (m != target) begin
      errors++;
      $display("FAIL %s: matching ticks=%0d, required %0d", name, m, target);
    end
  endtask

  task automatic count_until_event(input logic [3:0] rows, input logic [2:0] col, input int exp_m,
                                   input string name);
    int  m = 0;
    int  c = 0;
    bit  seen = 1'b0;
    while (!seen && c < 400) begin
      @(negedge clk);
      c++;
      if (evt_valid) seen = 1'b1;
      else if (tb_tick && key_col == col && key_row == rows) m++;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL %s_timeout: evt_valid=%b, required 1 within 400 clocks", name, evt_valid);
    end
    checks++;
    if (m != exp_m) begin
      errors++;
      $display("FAIL %s_latency: event after %0d matching ticks, required %0d", name, m, exp_m);
    end
  endtask

  task automatic release_key(input logic [3:0] code, input string name);
    clear_keys();
`ifdef KEYPAD_RELEASE_EN
    expect_event(1'b1, code);
`else
    if (code > 4'd11) $display("unexpected code argument %0d", code);
`endif
    wait_held(1'b0, name);
  endtask

  task automatic check_drained(input string name);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s: %0d expected events not seen, required 0", name, exp_q.size());
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    evt_ready = 1'b0;
    clear_keys();
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (key_col !== 3'b000) begin errors++; $display("FAIL reset_col: got %b, required 000", key_col); end
    checks++;
    if ({evt_valid, evt_release, key_held, overflow} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_flags: valid/rel/held/ovf=%b, required 0000",
               {evt_valid, evt_release, key_held, overflow});
    end
    checks++;
    if (evt_code !== 4'd0) begin errors++; $display("FAIL reset_code: got %0d, required 0", evt_code); end
    rst = 1'b0;
  endtask

  task automatic test_scan_rotation();
    logic [2:0] exp_col;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (key_col !== 3'b000) begin errors++; $display("FAIL pre_first_tick_col: got %b, required 000", key_col); end
    for (int k = 0; k < 12; k++) begin
      repeat ((k == 0) ? 1 : 4) @(posedge clk);
      @(negedge clk);
      exp_col = (k % 3 == 0) ? 3'b001 : ((k % 3 == 1) ? 3'b010 : 3'b100);
      checks++;
      if (key_col !== exp_col) begin
        errors++;
        $display("FAIL scan_col[%0d]: got %b, required %b", k, key_col, exp_col);
      end
      checks++;
      if (evt_valid !== 1'b0) begin errors++; $display("FAIL scan_idle_valid[%0d]: got %b, required 0", k, evt_valid); end
    end
  endtask

  task automatic test_single_press();
    evt_ready = 1'b1;
    expect_event(1'b0, 4'd5);
    set_key(4'b0010, 3'b010);
    count_until_event(4'b0010, 3'b010, 4, "press5");
    wait_ticks(6);
    check_drained("press5_once");
    checks++;
    if (key_held !== 1'b1) begin errors++; $display("FAIL press5_held: got %b, required 1", key_held); end
    checks++;
    if (evt_valid !== 1'b0) begin errors++; $display("FAIL press5_single: evt_valid=%b, required 0", evt_valid); end
    release_key(4'd5, "release5");
    wait_ticks(2);
    check_drained("release5_drain");
  endtask

  task automatic test_bounce();
    set_key(4'b0001, 3'b001);
    count_matches(4'b0001, 3'b001, 2, "bounce_hold");
    clear_keys();
    while (!tb_tick) @(negedge clk);
    @(negedge clk);
    checks++;
    if ({key_held, evt_valid} !== 2'b00) begin
      errors++;
      $display("FAIL bounce_reject: held/valid=%b, required 00", {key_held, evt_valid});
    end
    expect_event(1'b0, 4'd1);
    set_key(4'b0001, 3'b001);
    count_until_event(4'b0001, 3'b001, 4, "bounce_press");
    release_key(4'd1, "bounce_release");
    wait_ticks(2);
    check_drained("bounce_drain");
  endtask

  task automatic test_overflow();
    logic [3:0] rows [5];
    logic [2:0] cols [5];
    rows = '{4'b0001, 4'b0001, 4'b0001, 4'b0010, 4'b0010};
    cols = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010};
    evt_ready = 1'b0;
    hold_mode = 1'b1;
    model_occ = 0;
    dropped   = 0;
    for (int i = 0; i < 5; i++) begin
      set_key(rows[i], cols[i]);
      expect_event(1'b0, 4'(i + 1));
      wait_held(1'b1, "ovf_press");
      clear_keys();
`ifdef KEYPAD_RELEASE_EN
      expect_event(1'b1, 4'(i + 1));
`endif
      wait_held(1'b0, "ovf_release");
      wait_ticks(1);
      checks++;
      if (overflow !== (dropped != 0)) begin
        errors++;
        $display("FAIL overflow_after_press%0d: got %b, required %b", i + 1, overflow, dropped != 0);
      end
    end
    checks++;
    if (overflow !== 1'b1) begin errors++; $display("FAIL overflow_set: got %b, required 1", overflow); end
    hold_mode = 1'b0;
    evt_ready = 1'b1;
    wait_ticks(3);
    check_drained("overflow_drain");
    checks++;
    if ({evt_valid, overflow} !== 2'b01) begin
      errors++;
      $display("FAIL overflow_sticky: valid/ovf=%b, required 01", {evt_valid, overflow});
    end
  endtask

  task automatic test_ghost_and_hash();
    evt_ready = 1'b1;
    set_key(4'b1001, 3'b001);
    wait_ticks(12);
    checks++;
    if ({key_held, evt_valid} !== 2'b00) begin
      errors++;
      $display("FAIL ghost_reject: held/valid=%b, required 00", {key_held, evt_valid});
    end
    clear_keys();
    wait_ticks(1);
    expect_event(1'b0, 4'd11);
    set_key(4'b1000, 3'b100);
    count_until_event(4'b1000, 3'b100, 4, "hash_press");
    release_key(4'd11, "hash_release");
    wait_ticks(2);
    check_drained("hash_drain");
  endtask

  task automatic test_reset_mid_debounce();
    evt_ready = 1'b1;
    set_key(4'b0100, 3'b100);
    count_matches(4'b0100, 3'b100, 2, "k9_debounce");
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (key_col !== 3'b000) begin errors++; $display("FAIL rst_mid_col: got %b, required 000", key_col); end
    checks++;
    if ({evt_valid, key_held, overflow} !== 3'b000) begin
      errors++;
      $display("FAIL rst_mid_flags: valid/held/ovf=%b, required 000", {evt_valid, key_held, overflow});
    end
    rst = 1'b0;
    expect_event(1'b0, 4'd9);
    count_until_event(4'b0100, 3'b100, 4, "k9_after_rst");
    release_key(4'd9, "k9_release");
    wait_ticks(2);
    check_drained("k9_drain");
  endtask

  initial begin
    test_reset();
    test_scan_rotation();
    test_single_press();
    test_bounce();
    test_overflow();
    test_ghost_and_hash();
    test_reset_mid_debounce();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
